// File: rtl/mat_acc_pkg.sv
// ----------------------------------------------------------------------------
// mat_acc_pkg
//   Shared definitions for the matrix-accumulate datapath.
//   - C_BEATS: number of C elements the compute stage emits per result
//     (2x2 output tile). The result collector sizes its buffer from it.
//   - Collector FSM state encoding, as raw constants and as an enum.
// ----------------------------------------------------------------------------
package mat_acc_pkg;

  // Output beats per C result. The compute stage uses the same constant.
  localparam int C_BEATS = 4;

  // Raw encodings, kept stable so older checkers can decode the state bus.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_CAPTURE = S_CAPTURE,
    ST_DRAIN   = S_DRAIN,
    ST_HOLD    = S_HOLD
  } coll_state_t;

endpackage

// File: rtl/c_result_collector_result_regfile.sv
// ----------------------------------------------------------------------------
// result_regfile
//   DEPTH x DATA_W storage for one captured C result.
//   One write port, one registered read port (latency 1), synchronous clear
//   of the whole array, asynchronous active-low reset.
//
// Ports
//   clk       in   clock
//   rst_n     in   async active-low reset (array and read regs cleared)
//   clr       in   synchronous clear of every entry
//   wr_en     in   write strobe
//   wr_addr   in   write index
//   wr_data   in   write data
//   rd_en     in   read request, samples rd_addr
//   rd_addr   in   read index; indices >= DEPTH read as 0
//   rd_data   out  read data, valid the cycle after rd_en (0 otherwise)
//   rd_valid  out  rd_data valid strobe
// ----------------------------------------------------------------------------
module result_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Index range check done one bit wider so a non-power-of-two DEPTH still
  // rejects the unused upper addresses.
  logic rd_in_range;
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));

  // Storage. Clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port sees the pre-edge array contents, so a same-cycle write or
  // clear of the addressed entry returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en && rd_in_range) rd_data <= mem[rd_addr];
      else                      rd_data <= '0;
    end
  end

endmodule

// File: rtl/c_result_collector.sv
// ----------------------------------------------------------------------------
// c_result_collector
//   Sink for the compute stage's C AXI-Stream. Captures one result of N_OUT
//   beats into a local buffer, then holds it (tready low) until res_clear.
//   Length errors (short packet, or no tlast on the N_OUT-th beat) are
//   flagged on res_err; excess beats of a long packet are drained and
//   discarded. A registered random-access read port exposes the buffer.
//
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
//   are both high. tready depends only on state and res_clear, never on
//   tvalid, and is held low while res_clear is high so no beat is taken in
//   the cycle the capture is being restarted.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   s_axis_c_tdata    C element
//   s_axis_c_tvalid   beat valid
//   s_axis_c_tready   collector can accept
//   s_axis_c_tlast    last beat of result
//   res_clear         release held result / abort capture (ignored in IDLE)
//   rd_en, rd_addr    read request and buffer index
//   rd_data, rd_valid registered read data and strobe (latency 1)
//   res_valid         complete result held
//   res_err           held/in-progress result has a wrong beat count
//   res_beats         beats stored, saturates at N_OUT
//   res_done          one-cycle pulse on entry to HOLD
// ----------------------------------------------------------------------------
module c_result_collector
  import mat_acc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_OUT  = C_BEATS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          s_axis_c_tdata,
  input  logic                       s_axis_c_tvalid,
  output logic                       s_axis_c_tready,
  input  logic                       s_axis_c_tlast,
  input  logic                       res_clear,
  input  logic                       rd_en,
  input  logic [$clog2(N_OUT)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       res_valid,
  output logic                       res_err,
  output logic [$clog2(N_OUT+1)-1:0] res_beats,
  output logic                       res_done
);

  localparam int PTR_W   = $clog2(N_OUT);
  localparam int BEATS_W = $clog2(N_OUT+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_OUT-1);

  coll_state_t      state, state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic             err_nxt;

  logic at_last;
  logic clear_req;
  logic accept;
  logic wr_en;

  assign at_last   = (wr_ptr == LAST_PTR);
  assign clear_req = res_clear && (state != ST_IDLE);

  assign s_axis_c_tready = ((state == ST_CAPTURE) || (state == ST_DRAIN)) && !res_clear;
  assign accept          = s_axis_c_tvalid && s_axis_c_tready;
  // DRAIN accepts beats but never stores them.
  assign wr_en           = accept && (state == ST_CAPTURE);

  // Next-state logic. res_clear outranks any beat; tready is already low
  // then, so accept cannot be set in the same cycle anyway.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (clear_req) begin
          state_nxt = ST_CAPTURE;
        end else if (accept) begin
          if (at_last)             state_nxt = s_axis_c_tlast ? ST_HOLD : ST_DRAIN;
          else if (s_axis_c_tlast) state_nxt = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (clear_req)                    state_nxt = ST_CAPTURE;
        else if (accept && s_axis_c_tlast) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (clear_req) state_nxt = ST_CAPTURE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Error flag: decided by the beat that ends the buffered part of the
  // packet. A full buffer without tlast (long packet) or tlast before the
  // buffer is full (short packet) are both errors.
  always_comb begin
    err_nxt = res_err;
    if (clear_req) begin
      err_nxt = 1'b0;
    end else if (wr_en) begin
      if (at_last)             err_nxt = !s_axis_c_tlast;
      else if (s_axis_c_tlast) err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      res_beats <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_err   <= err_nxt;
      res_valid <= (state_nxt == ST_HOLD);
      res_done  <= (state_nxt == ST_HOLD) && (state != ST_HOLD);
      if (clear_req) begin
        wr_ptr    <= '0;
        res_beats <= '0;
      end else if (wr_en) begin
        // The last write leaves CAPTURE, so the pointer parks instead of
        // wrapping back onto entry 0.
        if (!at_last) wr_ptr <= wr_ptr + 1'b1;
        res_beats <= res_beats + 1'b1;
      end
    end
  end

  result_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (N_OUT),
    .ADDR_W (PTR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clear_req),
    .wr_en    (wr_en),
    .wr_addr  (wr_ptr),
    .wr_data  (s_axis_c_tdata),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // Structural invariants.
  a_no_write_without_ready : assert property (
    @(posedge clk) disable iff (!rst_n) wr_en |-> s_axis_c_tready);
  a_done_one_cycle : assert property (
    @(posedge clk) disable iff (!rst_n) res_done |=> !res_done);
  a_valid_only_in_hold : assert property (
    @(posedge clk) disable iff (!rst_n) res_valid |-> (state == ST_HOLD));
  a_beats_bounded : assert property (
    @(posedge clk) disable iff (!rst_n) res_beats <= BEATS_W'(N_OUT));

endmodule

// File: tb/tb_c_result_collector.sv
module tb_c_result_collector;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [31:0] s_axis_c_tdata = '0;
  logic        s_axis_c_tvalid = 1'b0;
  logic        s_axis_c_tready;
  logic        s_axis_c_tlast = 1'b0;
  logic        res_clear = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        res_valid;
  logic        res_err;
  logic [2:0]  res_beats;
  logic        res_done;

  c_result_collector #(.DATA_W(32), .N_OUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_c_tdata  (s_axis_c_tdata),
    .s_axis_c_tvalid (s_axis_c_tvalid),
    .s_axis_c_tready (s_axis_c_tready),
    .s_axis_c_tlast  (s_axis_c_tlast),
    .res_clear       (res_clear),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .res_valid       (res_valid),
    .res_err         (res_err),
    .res_beats       (res_beats),
    .res_done        (res_done)
  );

  // ---------------- vector table ----------------
  // One record = one clock. tready is checked before the edge (it is
  // combinational), everything else just after it.
  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic        tl;
    logic        clr;
    logic        re;
    logic [1:0]  ra;
    logic        e_rdy;
    logic        e_rdv;
    logic [31:0] e_rdd;
    logic        e_rv;
    logic        e_err;
    logic [2:0]  e_beats;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void push(input logic tv, input logic [31:0] td, input logic tl,
                               input logic clr, input logic re, input logic [1:0] ra,
                               input logic e_rdy, input logic e_rdv, input logic [31:0] e_rdd,
                               input logic e_rv, input logic e_err, input logic [2:0] e_beats,
                               input logic e_done);
    vec_t v;
    v.tv = tv; v.td = td; v.tl = tl; v.clr = clr; v.re = re; v.ra = ra;
    v.e_rdy = e_rdy; v.e_rdv = e_rdv; v.e_rdd = e_rdd;
    v.e_rv = e_rv; v.e_err = e_err; v.e_beats = e_beats; v.e_done = e_done;
    tbl.push_back(v);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"},    -1, 32'(s_axis_c_tready), 32'd0);
    chk({tag, "_rd_valid"},  -1, 32'(rd_valid),        32'd0);
    chk({tag, "_rd_data"},   -1, rd_data,              32'd0);
    chk({tag, "_res_valid"}, -1, 32'(res_valid),       32'd0);
    chk({tag, "_res_err"},   -1, 32'(res_err),         32'd0);
    chk({tag, "_res_beats"}, -1, 32'(res_beats),       32'd0);
    chk({tag, "_res_done"},  -1, 32'(res_done),        32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    s_axis_c_tvalid = v.tv;
    s_axis_c_tdata  = v.td;
    s_axis_c_tlast  = v.tl;
    res_clear       = v.clr;
    rd_en           = v.re;
    rd_addr         = v.ra;
    #1;
    chk("tready", idx, 32'(s_axis_c_tready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk("rd_valid",  idx, 32'(rd_valid),  32'(v.e_rdv));
    chk("rd_data",   idx, rd_data,        v.e_rdd);
    chk("res_valid", idx, 32'(res_valid), 32'(v.e_rv));
    chk("res_err",   idx, 32'(res_err),   32'(v.e_err));
    chk("res_beats", idx, 32'(res_beats), 32'(v.e_beats));
    chk("res_done",  idx, 32'(res_done),  32'(v.e_done));
    n_vec++;
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], base + i);
  endtask

  // ---------------- test ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk_all_zero("reset");
    rst_n = 1'b1;

    //   tv  td     tl clr re ra  rdy rdv rdd    rv err bt done
    // 1: clean capture, then read addr 2
    push(0, 32'h0,  0, 0, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // IDLE
    push(1, 32'h11, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'h22, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 2, 0);
    push(1, 32'h33, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 3, 0);
    push(1, 32'h44, 1, 0, 0, 0,  1,  0, 32'h0,  1, 0, 4, 1);
    push(0, 32'h0,  0, 0, 1, 2,  0,  1, 32'h33, 1, 0, 4, 0);
    // 2: backpressure while held, then release
    for (int k = 0; k < 9; k++)
      push(1, 32'hFF, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 4, 0);
    push(1, 32'hFF, 0, 0, 1, 0,  0,  1, 32'h11, 1, 0, 4, 0);
    push(1, 32'hFF, 0, 1, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // clear
    for (int k = 0; k < 4; k++)
      push(0, 32'h0, 0, 0, 1, 2'(k), 1, 1, 32'h0, 0, 0, 0, 0);
    // 3: short packet
    push(1, 32'hA1, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'hA2, 1, 0, 0, 0,  1,  0, 32'h0,  1, 1, 2, 1);
    push(0, 32'h0,  0, 0, 1, 1,  0,  1, 32'hA2, 1, 1, 2, 0);
    push(0, 32'h0,  0, 0, 1, 2,  0,  1, 32'h0,  1, 1, 2, 0);
    push(0, 32'h0,  0, 0, 1, 3,  0,  1, 32'h0,  1, 1, 2, 0);
    push(0, 32'h0,  0, 0, 1, 0,  0,  1, 32'hA1, 1, 1, 2, 0);
    push(0, 32'h0,  0, 1, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // clear
    // 4: long packet, beats 5/6 drained
    push(1, 32'h1,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'h2,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 2, 0);
    push(1, 32'h3,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 3, 0);
    push(1, 32'h4,  0, 0, 0, 0,  1,  0, 32'h0,  0, 1, 4, 0);   // -> DRAIN
    push(1, 32'h5,  0, 0, 0, 0,  1,  0, 32'h0,  0, 1, 4, 0);
    push(1, 32'h6,  1, 0, 0, 0,  1,  0, 32'h0,  1, 1, 4, 1);
    for (int k = 0; k < 4; k++)
      push(0, 32'h0, 0, 0, 1, 2'(k), 0, 1, 32'(k + 1), 1, 1, 4, 0);
    push(0, 32'h0,  0, 1, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // clear
    // 5: gapped beats, abort with tvalid high, then clean 5..8
    push(1, 32'h91, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(0, 32'h0,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'h92, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 2, 0);
    push(1, 32'h93, 0, 1, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // clear, beat refused
    push(1, 32'h5,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(0, 32'h0,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'h6,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 2, 0);
    push(1, 32'h7,  0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 3, 0);
    push(1, 32'h8,  1, 0, 0, 0,  1,  0, 32'h0,  1, 0, 4, 1);
    for (int k = 0; k < 4; k++)
      push(0, 32'h0, 0, 0, 1, 2'(k), 0, 1, 32'(k + 5), 1, 0, 4, 0);
    push(0, 32'h0,  0, 1, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // clear
    // 6 (first half): two beats in, read addr 0 on the second
    push(1, 32'hC1, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'hC2, 0, 0, 1, 0,  1,  1, 32'hC1, 0, 0, 2, 0);
    run_table(0);

    // 6: asynchronous reset mid-capture, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2;
    rst_n = 1'b1;
    s_axis_c_tvalid = 1'b0;
    rd_en = 1'b0;

    tbl.delete();
    push(0, 32'h0,  0, 0, 0, 0,  0,  0, 32'h0,  0, 0, 0, 0);   // IDLE, tready low
    push(0, 32'h0,  0, 0, 1, 1,  1,  1, 32'h0,  0, 0, 0, 0);   // old 0xC2 gone
    push(1, 32'hD1, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 1, 0);
    push(1, 32'hD2, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 2, 0);
    push(1, 32'hD3, 0, 0, 0, 0,  1,  0, 32'h0,  0, 0, 3, 0);
    push(1, 32'hD4, 1, 0, 0, 0,  1,  0, 32'h0,  1, 0, 4, 1);
    for (int k = 0; k < 4; k++)
      push(0, 32'h0, 0, 0, 1, 2'(k), 0, 1, 32'hD1 + 32'(k), 1, 0, 4, 0);
    run_table(1000);

    @(negedge clk);
    rd_en = 1'b0;
    s_axis_c_tvalid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
